logic_result_stage: RTL and testbench
=====================================

// Module: logic_result_stage
// PURPOSE
//  Output register stage directly downstream of the 32-bit bitwise logic gates (xnor/and/or/xor).
//  Captures gate result Y plus its opcode through a valid/ready handshake into a 2-entry skid
//  buffer, computes status flags at capture time and presents them registered to the ALU writeback.
//  Decouples combinational gate timing from writeback back-pressure without dropping results.
// PARAMETERS
//  WIDTH   32  data width of the gate result
//  OPW     2   opcode tag width (00 and, 01 or, 10 xor, 11 xnor; carried untouched)
//  CNTW    16  width of the delivered-result counter
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      upstream result Y valid this cycle
//  in_ready   out  1      stage can accept a result this cycle
//  in_y       in   WIDTH  gate output Y
//  in_op      in   OPW    opcode that produced in_y
//  out_valid  out  1      head entry valid
//  out_ready  in   1      writeback consumes head entry this cycle
//  out_y      out  WIDTH  head result
//  out_op     out  OPW    head opcode
//  out_zero   out  1      head result == 0
//  out_ones   out  1      head result == all ones
//  out_parity out  1      XOR-reduction of head result (1 = odd popcount)
//  out_count  out  CNTW   number of results delivered since reset
// BEHAVIOUR
//  - Reset (rst=1 at edge): state EMPTY, out_valid=0, in_ready=1, out_y=0, out_op=0,
//    out_zero=0, out_ones=0, out_parity=0, out_count=0. Reset wins over any same-cycle handshake;
//    entries in flight are discarded, not delivered.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Transfers only on these terms.
//  - States: EMPTY (0 entries), ONE (1), FULL (2).
//    EMPTY: push -> ONE.  ONE: push&!pop -> FULL; pop&!push -> EMPTY; push&pop -> ONE.
//    FULL: pop -> ONE (push impossible, in_ready=0).  No transition without push/pop.
//  - in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. Asserts cycle after the pop out of FULL.
//  - Latency: result pushed at edge N is on out_* after edge N (visible cycle N+1) when stage
//    was EMPTY, or when ONE with a simultaneous pop. Order strictly FIFO.
//  - Flags computed from in_y at push and stored with the entry; outputs never recompute.
//  - out_* hold stable while out_valid=1 and out_ready=0. When out_valid=0, out_* hold last value.
//  - out_count increments by 1 on each pop, wraps 2^CNTW-1 -> 0 silently.
//  - in_y/in_op ignored when push=0; X on them must not propagate into state.
// TESTING
//  1 Reset mid-FULL: fill 2 entries, assert rst one cycle -> out_valid=0, in_ready=1, out_count=0.
//  2 Single pass, out_ready=1: in_y=32'h00000000 op=11 -> next cycle out_y=0, zero=1, ones=0,
//    parity=0; out_count=1.
//  3 in_y=32'hFFFFFFFF op=11 -> ones=1, zero=0, parity=0; in_y=32'h6AAEEAA6 -> parity=0, both flags 0.
//  4 Back-pressure: out_ready=0, push 32'h11111111 then 32'h22222222 -> in_ready=0 after 2nd push,
//    3rd value held off; release out_ready -> outputs 11111111 then 22222222 in order, no loss.
//  5 Streaming: in_valid=out_ready=1 for 100 cycles, incrementing data -> one result per cycle,
//    state stays ONE, out_count=100.
//  6 Wrap: CNTW=4, deliver 17 results -> out_count sequence ends 15,0,1.

Source files
------------

// File: rtl/logic_result_stage.sv
// rtl/logic_result_stage.sv - two-entry skid register stage for bitwise gate results with status flags
// The head entry drives out_*; the skid entry absorbs one result while writeback stalls.
module logic_result_stage #(
  parameter int WIDTH = 32,
  parameter int OPW   = 2,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNTW-1:0]  out_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic             push, pop;
  logic             in_zero, in_ones, in_parity;
  logic [WIDTH-1:0] skid_y;
  logic [OPW-1:0]   skid_op;
  logic             skid_zero, skid_ones, skid_parity;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);

  // Flags are taken once from the incoming result and travel with the entry.
  assign in_zero   = ~|in_y;
  assign in_ones   = &in_y;
  assign in_parity = ^in_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // in_ready is a flop so upstream never sees a combinational path from out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= (state_nx != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_y       <= '0;
      out_op      <= '0;
      out_zero    <= 1'b0;
      out_ones    <= 1'b0;
      out_parity  <= 1'b0;
      skid_y      <= '0;
      skid_op     <= '0;
      skid_zero   <= 1'b0;
      skid_ones   <= 1'b0;
      skid_parity <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            out_y      <= in_y;
            out_op     <= in_op;
            out_zero   <= in_zero;
            out_ones   <= in_ones;
            out_parity <= in_parity;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_y      <= in_y;
            out_op     <= in_op;
            out_zero   <= in_zero;
            out_ones   <= in_ones;
            out_parity <= in_parity;
          end else if (push) begin
            skid_y      <= in_y;
            skid_op     <= in_op;
            skid_zero   <= in_zero;
            skid_ones   <= in_ones;
            skid_parity <= in_parity;
          end
        end
        FULL: begin
          if (pop) begin
            out_y      <= skid_y;
            out_op     <= skid_op;
            out_zero   <= skid_zero;
            out_ones   <= skid_ones;
            out_parity <= skid_parity;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (pop) begin
      out_count <= out_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_logic_result_stage.sv
// tb/tb_logic_result_stage.sv - randomized and directed checks of logic_result_stage against a queue model
module tb_logic_result_stage;

  localparam int WIDTH = 32;
  localparam int OPW   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic [OPW-1:0]   in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [OPW-1:0]   out_op;
  logic             out_zero, out_ones, out_parity;
  logic [15:0]      out_count;

  logic             n_in_ready, n_out_valid;
  logic [WIDTH-1:0] n_out_y;
  logic [OPW-1:0]   n_out_op;
  logic             n_out_zero, n_out_ones, n_out_parity;
  logic [3:0]       n_out_count;

  always #5 clk = ~clk;

  logic_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity), .out_count(out_count)
  );

  logic_result_stage #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(4)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_y(in_y), .in_op(in_op),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_y(n_out_y), .out_op(n_out_op),
    .out_zero(n_out_zero), .out_ones(n_out_ones), .out_parity(n_out_parity), .out_count(n_out_count)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two results plus the last head shown.
  typedef struct {
    logic [WIDTH-1:0] y;
    logic [OPW-1:0]   op;
  } entry_t;

  entry_t           q[$];
  bit               model_live = 0;
  int unsigned      m_count = 0;
  logic [WIDTH-1:0] sh_y;
  logic [OPW-1:0]   sh_op;
  logic             sh_zero, sh_ones, sh_parity;

  always @(posedge clk) begin
    bit push_m, pop_m;
    entry_t e;
    if (rst === 1'b1) begin
      q.delete();
      m_count   = 0;
      sh_y      = '0;
      sh_op     = '0;
      sh_zero   = 1'b0;
      sh_ones   = 1'b0;
      sh_parity = 1'b0;
      model_live = 1;
    end else if (model_live) begin
      push_m = (in_valid === 1'b1) && (q.size() < 2);
      pop_m  = (q.size() > 0) && (out_ready === 1'b1);
      if (pop_m) begin
        void'(q.pop_front());
        m_count++;
      end
      if (push_m) begin
        e.y  = in_y;
        e.op = in_op;
        q.push_back(e);
      end
      if (q.size() > 0) begin
        sh_y      = q[0].y;
        sh_op     = q[0].op;
        sh_zero   = (q[0].y == 0);
        sh_ones   = (q[0].y == 32'hFFFF_FFFF);
        sh_parity = ($countones(q[0].y) % 2) == 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("in_ready",   64'(in_ready),   64'(q.size() < 2));
      check("out_valid",  64'(out_valid),  64'(q.size() > 0));
      check("out_y",      64'(out_y),      64'(sh_y));
      check("out_op",     64'(out_op),     64'(sh_op));
      check("out_zero",   64'(out_zero),   64'(sh_zero));
      check("out_ones",   64'(out_ones),   64'(sh_ones));
      check("out_parity", 64'(out_parity), 64'(sh_parity));
      check("out_count",  64'(out_count),  64'(m_count % 65536));
      check("n_count",    64'(n_out_count), 64'(m_count % 16));
      check("n_out_y",    64'(n_out_y),    64'(sh_y));
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] y, input logic [OPW-1:0] op,
                      input logic r);
    in_valid  = v;
    in_y      = y;
    in_op     = op;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 'x, 'x, 1'b0);
    rst = 1'b0;
  endtask

  int          wait_cnt;
  logic [3:0]  n_hist[$];
  logic [31:0] got[$];

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_y = '0;
    in_op = '0;
    #1;
    step(1'b0, 'x, 'x, 1'b0);
    step(1'b0, 'x, 'x, 1'b0);
    rst = 1'b0;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd1);

    // Reset while holding two entries; a same-cycle handshake must lose to reset.
    step(1'b1, 32'hAAAA_0001, 2'b00, 1'b0);
    step(1'b1, 32'hAAAA_0002, 2'b01, 1'b0);
    check("full_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step(1'b1, 32'hBBBB_0003, 2'b10, 1'b1);
    rst = 1'b0;
    check("rst_full_valid", 64'(out_valid), 64'd0);
    check("rst_full_ready", 64'(in_ready), 64'd1);
    check("rst_full_count", 64'(out_count), 64'd0);
    check("rst_full_y", 64'(out_y), 64'd0);

    // Flag patterns with writeback always ready.
    step(1'b1, 32'h0000_0000, 2'b11, 1'b1);
    check("z_y", 64'(out_y), 64'd0);
    check("z_flags", 64'({out_zero, out_ones, out_parity}), 64'b100);
    check("z_op", 64'(out_op), 64'd3);
    step(1'b1, 32'hFFFF_FFFF, 2'b11, 1'b1);
    check("z_count", 64'(out_count), 64'd1);
    check("o_flags", 64'({out_zero, out_ones, out_parity}), 64'b010);
    step(1'b1, 32'h6AAE_EAA6, 2'b10, 1'b1);
    check("p_flags", 64'({out_zero, out_ones, out_parity}), 64'b000);
    step(1'b1, 32'h0000_0001, 2'b01, 1'b1);
    check("odd_parity", 64'({out_zero, out_ones, out_parity}), 64'b001);
    step(1'b0, 'x, 'x, 1'b1);
    check("drain_valid", 64'(out_valid), 64'd0);
    check("hold_y", 64'(out_y), 64'h1);

    // Back-pressure: third value offered while full is held off until space frees.
    step(1'b1, 32'h1111_1111, 2'b00, 1'b0);
    step(1'b1, 32'h2222_2222, 2'b00, 1'b0);
    check("bp_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h3333_3333, 2'b00, 1'b0);
    check("bp_hold_y", 64'(out_y), 64'h1111_1111);
    got.delete();
    for (int i = 0; i < 6; i++) begin
      if (out_valid) got.push_back(out_y);
      step(1'b0, 'x, 'x, 1'b1);
    end
    check("bp_none_lost", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      check("bp_first", 64'(got[0]), 64'h1111_1111);
      check("bp_second", 64'(got[1]), 64'h2222_2222);
    end

    // Wait for in_ready, then push the held-off value (bounded).
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 10) begin
      step(1'b0, 'x, 'x, 1'b1);
      wait_cnt++;
    end
    check("ready_timeout", 64'(wait_cnt < 10), 64'd1);

    // Streaming: one result per cycle for 100 cycles.
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 32'(i + 1), 2'(i), 1'b1);
    check("stream_valid", 64'(out_valid), 64'd1);
    check("stream_ready", 64'(in_ready), 64'd1);
    step(1'b0, 'x, 'x, 1'b1);
    check("stream_count", 64'(out_count), 64'd100);

    // Counter wrap on the 4-bit instance.
    do_reset();
    n_hist.delete();
    for (int i = 0; i < 18; i++) begin
      step(i < 17, 32'(i * 7), 2'(i), 1'b1);
      if (i > 0) n_hist.push_back(n_out_count);
    end
    check("wrap_len", 64'(n_hist.size()), 64'd17);
    if (n_hist.size() == 17) begin
      check("wrap_15", 64'(n_hist[14]), 64'd15);
      check("wrap_0",  64'(n_hist[15]), 64'd0);
      check("wrap_1",  64'(n_hist[16]), 64'd1);
    end
    check("wrap_wide", 64'(out_count), 64'd17);

    // Randomized traffic with X on idle data.
    for (int i = 0; i < 2000; i++) begin
      logic v;
      v = ($urandom_range(0, 99) < 60);
      step(v, v ? 32'($urandom) : 'x, v ? 2'($urandom) : 'x, $urandom_range(0, 99) < 55);
      if (i == 1000) do_reset();
    end
    step(1'b0, 'x, 'x, 1'b1);
    step(1'b0, 'x, 'x, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
